// File: rtl/rr_arbiter_mux.sv
// rr_arbiter_mux
// N-input arbiter feeding a single registered output stage with a
// valid/ready handshake. Round-robin or fixed-priority selection, one word
// per cycle sustained, one cycle from grant to Out_Valid_o.

module rr_arbiter_mux #(
   parameter int NBits     = 32,
   parameter int NChannels = 4,
   parameter int ArbMode   = 0,
   localparam int ChW      = (NChannels > 1) ? $clog2(NChannels) : 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NChannels-1:0]       Req_Valid_i,
   input  logic [NChannels*NBits-1:0] Req_Data_i,
   output logic [NChannels-1:0]       Req_Ready_o,
   output logic                       Out_Valid_o,
   output logic [NBits-1:0]           Out_Data_o,
   output logic [ChW-1:0]             Out_Channel_o,
   input  logic                       Out_Ready_i
);

   // Output stage and arbitration pointer
   logic                 r_out_valid;
   logic [NBits-1:0]     r_out_data;
   logic [ChW-1:0]       r_out_channel;
   logic [ChW-1:0]       r_last_grant;

   // Arbitration results
   logic                 w_load;
   logic                 w_found;
   logic                 w_grant;
   logic [ChW-1:0]       w_grant_idx;
   logic [ChW-1:0]       w_cand_idx;
   logic [NChannels-1:0] w_grant_onehot;
   logic [NBits-1:0]     w_ch_data [NChannels];
   int                   w_cand;

   // Split the flat data bus into one word per channel.
   for (genvar g = 0; g < NChannels; g++) begin : g_split
      assign w_ch_data[g] = Req_Data_i[g*NBits +: NBits];
   end

   // The output register can take a new word when empty or being drained.
   assign w_load = ~r_out_valid | Out_Ready_i;

   // Search for the winning channel: upward from the slot after the last
   // grant (round-robin) or upward from channel 0 (fixed priority).
   // last_grant <= NChannels-1, so a single wrap subtraction is enough.
   always_comb begin
      w_found     = 1'b0;
      w_grant_idx = {ChW{1'b0}};
      w_cand      = 0;
      w_cand_idx  = {ChW{1'b0}};
      for (int i = 0; i < NChannels; i++) begin
         if (ArbMode == 1) begin
            w_cand = i;
         end else begin
            w_cand = int'(r_last_grant) + 1 + i;
            if (w_cand >= NChannels) begin
               w_cand = w_cand - NChannels;
            end else begin
               w_cand = w_cand;
            end
         end
         w_cand_idx = ChW'(w_cand);
         if (!w_found && Req_Valid_i[w_cand_idx]) begin
            w_found     = 1'b1;
            w_grant_idx = w_cand_idx;
         end else begin
            w_found     = w_found;
            w_grant_idx = w_grant_idx;
         end
      end
   end

   // A grant is only issued when the output stage can accept and not in reset.
   assign w_grant = w_load & w_found & ~reset;

   // One-hot acceptance strobe back to the winning channel.
   always_comb begin
      w_grant_onehot = {NChannels{1'b0}};
      if (w_grant) begin
         w_grant_onehot[w_grant_idx] = 1'b1;
      end else begin
         w_grant_onehot = {NChannels{1'b0}};
      end
   end

   // Output register: load on grant, empty when drained with nothing
   // pending, otherwise hold. Reset discards any held word and points
   // last_grant at the top channel so channel 0 is favoured next.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_valid   <= 1'b0;
         r_out_data    <= {NBits{1'b0}};
         r_out_channel <= {ChW{1'b0}};
         r_last_grant  <= ChW'(NChannels - 1);
      end else if (w_grant) begin
         r_out_valid   <= 1'b1;
         r_out_data    <= w_ch_data[w_grant_idx];
         r_out_channel <= w_grant_idx;
         r_last_grant  <= w_grant_idx;
      end else if (w_load) begin
         r_out_valid   <= 1'b0;
         r_out_data    <= r_out_data;
         r_out_channel <= r_out_channel;
         r_last_grant  <= r_last_grant;
      end else begin
         r_out_valid   <= r_out_valid;
         r_out_data    <= r_out_data;
         r_out_channel <= r_out_channel;
         r_last_grant  <= r_last_grant;
      end
   end

   assign Req_Ready_o   = w_grant_onehot;
   assign Out_Valid_o   = r_out_valid;
   assign Out_Data_o    = r_out_data;
   assign Out_Channel_o = r_out_channel;

endmodule
